prio_encoder_rr: RTL and testbench
==================================

PRIO_ENCODER_RR -- requirements
Module: prio_encoder_rr

Interface
REQ-001 The module SHALL take parameter N, default 8, giving the number of request inputs (legal range 2..64, any integer).
REQ-002 The module SHALL take parameter W, default $clog2(N), giving the index width; overriding W SHALL be unsupported.
REQ-003 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 Port req, input, N bits: request vector; bit i is request i.
REQ-006 Port mode, input, 1 bit: selects priority order (0 = fixed, 1 = round-robin); sampled together with req.
REQ-007 Port out_ready, input, 1 bit: the consumer accepts the held result.
REQ-008 Port valid, output, 1 bit: the held result contains a grant.
REQ-009 Port idx, output, W bits: binary index of the granted request.
REQ-010 Port grant, output, N bits: one-hot form of idx; all zero when valid=0.

Function
REQ-011 The load condition SHALL be load = !valid || out_ready.
REQ-012 When load=1 at a rising edge, the block SHALL sample req/mode and register valid/idx/grant; when load=0, the outputs SHALL hold unchanged regardless of req/mode.
REQ-013 Latency SHALL be exactly one cycle from the sampling edge to the outputs; no combinational path SHALL exist from req/mode to any output.
REQ-014 If the sampled req is all zero, the block SHALL register valid=0, idx=0, grant=0.
REQ-015 Fixed mode (mode=0): the highest set index of req SHALL win.
REQ-016 Round-robin mode (mode=1): the search order SHALL be ptr-1, ptr-2, ..., 0, N-1, ..., ptr (descending with wrap), and the first set bit SHALL win.
REQ-017 The internal pointer ptr (W bits) SHALL be set to idx on every accepted transfer (valid && out_ready), in either mode.
REQ-018 When acceptance and load coincide in the same cycle, the new search SHALL use the updated pointer, i.e. base = idx instead of ptr.
REQ-019 With ptr=0 the round-robin order SHALL equal the fixed order (N-1 first).
REQ-020 Back-to-back transfers SHALL sustain one grant per cycle while out_ready=1.
REQ-021 A request withdrawn while its grant is held SHALL not cancel the held grant; the grant remains until accepted.
REQ-022 A mode change SHALL take effect at the next load edge only; ptr SHALL not be altered by the mode change itself.
REQ-023 out_ready asserted while valid=0 SHALL not change ptr.

Reset
REQ-024 At a rising edge with rst_n=0, the block SHALL set valid=0, idx=0, grant=0, ptr=0, with priority over load and accept.
REQ-025 rst_n=0 mid-transfer SHALL discard the held grant without updating ptr; the first load after release SHALL sample normally.

Verification (N=8)
REQ-026 Fixed priority: after reset, mode=0, req=8'b0000_0110, out_ready=1 -> one cycle later valid=1, idx=2, grant=8'b0000_0100.
REQ-027 Round-robin rotation: after reset, mode=1, req=8'hFF held, out_ready=1 -> idx sequence 7,6,5,4,3,2,1,0,7, one per cycle, valid=1 throughout.
REQ-028 Backpressure: hold grant idx=5 with out_ready=0, change req to 8'h01 for 3 cycles -> idx=5 and grant=8'h20 held; raise out_ready -> next cycle idx=0.
REQ-029 Empty: req=8'h00 with out_ready=1 -> valid=0, idx=0, grant=8'h00; then req=8'h80 -> next cycle valid=1, idx=7.
REQ-030 Round-robin skip: mode=1, ptr=3 (grant 3 accepted), req=8'b0000_1001 -> idx=0; after acceptance -> idx=3.
REQ-031 Reset mid-operation: mode=1 after grants 7,6, assert rst_n=0 for one edge -> valid=0, grant=0; release with req=8'hFF -> idx=7 (ptr restored to 0).

Source files
------------

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin order and a valid/ready output stage.
// The round-robin search is descending from ptr-1 with wrap, so ptr=0 gives the same order as fixed priority.
module prio_encoder_rr #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         mode,
    input  logic         out_ready,
    output logic         valid,
    output logic [W-1:0] idx,
    output logic [N-1:0] grant
);

    logic         r_valid;
    logic [W-1:0] r_idx;
    logic [N-1:0] r_grant;
    logic [W-1:0] r_ptr;

    logic         w_load;
    logic         w_accept;
    logic [W-1:0] w_base;
    logic [N-1:0] w_below;
    logic [N-1:0] w_req_low;
    logic [W-1:0] w_all_idx;
    logic [W-1:0] w_low_idx;
    logic         w_any;
    logic         w_use_low;
    logic [W-1:0] w_sel_idx;
    logic [N-1:0] w_onehot;

    assign w_load   = !r_valid || out_ready;
    assign w_accept = r_valid && out_ready;
    // A transfer accepted in this cycle moves the pointer, and the new search must already see it.
    assign w_base   = w_accept ? r_idx : r_ptr;

    // Descending search from base-1 with wrap equals: highest request below base, else highest overall.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_below
            assign w_below[gi] = (W'(gi) < w_base);
        end
    endgenerate

    assign w_req_low = req & w_below;
    assign w_any     = |req;
    assign w_use_low = mode && (|w_req_low);

    always_comb begin
        w_all_idx = '0;
        w_low_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                w_all_idx = W'(i);
            end
            if (w_req_low[i]) begin
                w_low_idx = W'(i);
            end
        end
    end

    assign w_sel_idx = w_use_low ? w_low_idx : w_all_idx;

    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign w_onehot[gi] = w_any && (w_sel_idx == W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_idx   <= '0;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            if (w_accept) begin
                r_ptr <= r_idx;
            end
            if (w_load) begin
                r_valid <= w_any;
                r_idx   <= w_any ? w_sel_idx : '0;
                r_grant <= w_onehot;
            end
        end
    end

    assign valid = r_valid;
    assign idx   = r_idx;
    assign grant = r_grant;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Self-checking bench for prio_encoder_rr (N=8): directed scenarios plus randomized traffic
// compared against a search-order reference model.
module tb_prio_encoder_rr;

    localparam int N = 8;
    localparam int W = 3;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         mode;
    logic         out_ready;
    logic         valid;
    logic [W-1:0] idx;
    logic [N-1:0] grant;

    int n_tests;
    int n_fail;

    // reference state
    logic m_valid;
    int   m_idx;
    int   m_ptr;

    prio_encoder_rr #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .mode      (mode),
        .out_ready (out_ready),
        .valid     (valid),
        .idx       (idx),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Walk the order base-1, base-2, ..., 0, N-1, ..., base; fixed mode behaves as base=0.
    function automatic int pick(input logic [N-1:0] r, input int base, input logic m);
        int b;
        int j;
        b = m ? base : 0;
        for (int k = 1; k <= N; k++) begin
            j = (b - k + N) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_edge();
        logic acc;
        logic ld;
        int   base;
        int   p;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_idx   = 0;
            m_ptr   = 0;
        end else begin
            acc  = m_valid && out_ready;
            ld   = !m_valid || out_ready;
            base = acc ? m_idx : m_ptr;
            if (acc) m_ptr = m_idx;
            if (ld) begin
                p = pick(req, base, mode);
                m_valid = (p >= 0);
                m_idx   = (p >= 0) ? p : 0;
            end
        end
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic m, input logic rdy, input logic rn,
                         input string tag);
        logic [N-1:0] exp_grant;
        req       = r;
        mode      = m;
        out_ready = rdy;
        rst_n     = rn;
        @(posedge clk);
        model_edge();
        #1;
        exp_grant = m_valid ? (N'(1) << m_idx) : '0;
        chk({tag, "_valid"}, 64'(valid), 64'(m_valid));
        chk({tag, "_idx"},   64'(idx),   64'(m_idx));
        chk({tag, "_grant"}, 64'(grant), 64'(exp_grant));
        $display("[TB] %s req=%02h mode=%0d rdy=%0d rst_n=%0d -> valid=%0d idx=%0d grant=%02h",
                 tag, r, m, rdy, rn, valid, idx, grant);
    endtask

    task automatic do_reset();
        cycle(8'h00, 1'b0, 1'b0, 1'b0, "rst");
    endtask

    initial begin
        int exp_seq [9];
        n_tests   = 0;
        n_fail    = 0;
        m_valid   = 1'b0;
        m_idx     = 0;
        m_ptr     = 0;
        req       = '0;
        mode      = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;

        // reset state
        do_reset();
        chk("reset_valid", 64'(valid), 64'd0);
        chk("reset_grant", 64'(grant), 64'd0);

        // fixed priority
        cycle(8'b0000_0110, 1'b0, 1'b1, 1'b1, "fixed");
        chk("fixed_idx", 64'(idx), 64'd2);
        chk("fixed_grant", 64'(grant), 64'h04);

        // round-robin rotation
        do_reset();
        exp_seq = '{7, 6, 5, 4, 3, 2, 1, 0, 7};
        for (int i = 0; i < 9; i++) begin
            cycle(8'hFF, 1'b1, 1'b1, 1'b1, "rr_rot");
            chk("rr_rot_seq", 64'(idx), 64'(exp_seq[i]));
            chk("rr_rot_valid", 64'(valid), 64'd1);
        end

        // backpressure holds grant while req changes
        do_reset();
        cycle(8'h20, 1'b0, 1'b0, 1'b1, "bp_load");
        for (int i = 0; i < 3; i++) begin
            cycle(8'h01, 1'b0, 1'b0, 1'b1, "bp_hold");
            chk("bp_hold_idx", 64'(idx), 64'd5);
            chk("bp_hold_grant", 64'(grant), 64'h20);
        end
        cycle(8'h01, 1'b0, 1'b1, 1'b1, "bp_rel");
        chk("bp_rel_idx", 64'(idx), 64'd0);

        // empty request
        cycle(8'h00, 1'b0, 1'b1, 1'b1, "empty");
        chk("empty_valid", 64'(valid), 64'd0);
        chk("empty_grant", 64'(grant), 64'h00);
        cycle(8'h80, 1'b0, 1'b1, 1'b1, "after_empty");
        chk("after_empty_idx", 64'(idx), 64'd7);

        // round-robin skip
        do_reset();
        cycle(8'h08, 1'b1, 1'b1, 1'b1, "skip_a");
        chk("skip_a_idx", 64'(idx), 64'd3);
        cycle(8'h09, 1'b1, 1'b1, 1'b1, "skip_b");
        chk("skip_b_idx", 64'(idx), 64'd0);
        cycle(8'h09, 1'b1, 1'b1, 1'b1, "skip_c");
        chk("skip_c_idx", 64'(idx), 64'd3);

        // reset mid-operation restores ptr
        do_reset();
        cycle(8'hFF, 1'b1, 1'b1, 1'b1, "mid_a");
        chk("mid_a_idx", 64'(idx), 64'd7);
        cycle(8'hFF, 1'b1, 1'b1, 1'b1, "mid_b");
        chk("mid_b_idx", 64'(idx), 64'd6);
        cycle(8'hFF, 1'b1, 1'b1, 1'b0, "mid_rst");
        chk("mid_rst_valid", 64'(valid), 64'd0);
        chk("mid_rst_grant", 64'(grant), 64'd0);
        cycle(8'hFF, 1'b1, 1'b1, 1'b1, "mid_rel");
        chk("mid_rel_idx", 64'(idx), 64'd7);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            logic [N-1:0] r;
            r = 8'($urandom);
            if ($urandom_range(0, 3) == 0) r = r & 8'($urandom);
            if ($urandom_range(0, 9) == 0) r = '0;
            cycle(r, 1'($urandom), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 49) != 0), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
